reg_file_sb: RTL and testbench

- Parametrised multi-entry register file with byte-enabled writes, two read ports and a per-entry scoreboard of pending writes.
- Successor to the fixed 64-bit single register: generalises width and depth, and adds write-through bypass and producer tracking.
- Sits between decode/issue (sets pending bits) and writeback (writes data, clears pending bits) in the CPU datapath.

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_sb_entry.sv | 33 +++
 rtl/reg_file_sb.sv | 118 +++++++++++
 tb/tb_reg_file_sb.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants, typedefs and helpers for the reg_file_sb register file.
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_DEPTH = 32;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

    typedef logic [DEFAULT_AW-1:0]      addr_t;
    typedef logic [DEFAULT_WIDTH/8-1:0] be_t;

    function automatic int byte_lanes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/reg_file_sb_entry.sv
// reg_entry: one WIDTH-bit register with per-byte write enables and async active-low clear.
module reg_entry
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [byte_lanes(WIDTH)-1:0] i_be,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_q
);

    localparam int NB = byte_lanes(WIDTH);

    logic [WIDTH-1:0] r_q;

    // Byte-lane storage; lanes without an enable hold their value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    r_q[8*b +: 8] <= i_data[8*b +: 8];
                end
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with byte-enabled writeback, two read ports and a pending-write scoreboard.
// Optional write-through bypass on the read ports is enabled by defining RF_BYPASS_EN.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [AW-1:0]                rd_addr_a,
    output logic [WIDTH-1:0]             rd_data_a,
    output logic                         rd_valid_a,
    input  logic [AW-1:0]                rd_addr_b,
    output logic [WIDTH-1:0]             rd_data_b,
    output logic                         rd_valid_b,
    input  logic                         we,
    input  logic [AW-1:0]                wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [byte_lanes(WIDTH)-1:0] wr_be,
    input  logic                         issue_valid,
    input  logic [AW-1:0]                issue_addr,
    output logic                         issue_ready,
    output logic [AW:0]                  busy_count
);

    localparam int NB = byte_lanes(WIDTH);
    localparam bit ZR = (ZERO_REG != 0);

    logic [DEPTH-1:0] r_pending;
    logic [AW:0]      r_busy_count;
    logic [DEPTH-1:0] w_pending_next;
    logic [WIDTH-1:0] w_entry_q [DEPTH];
    logic             w_wr_zero;
    logic             w_wr_en;
    logic             w_wr_clear;
    logic             w_issue_zero;
    logic             w_issue_acc;
    logic [AW-1:0]    w_rd_addr  [2];
    logic [WIDTH-1:0] w_rd_data  [2];
    logic             w_rd_valid [2];

    assign w_wr_zero    = ZR && (wr_addr == '0);
    assign w_wr_en      = we && !w_wr_zero;
    assign w_wr_clear   = w_wr_en && r_pending[wr_addr];
    assign w_issue_zero = ZR && (issue_addr == '0);
    // A pending destination may be re-issued only when its producer retires this cycle.
    assign issue_ready  = !r_pending[issue_addr] || (we && (wr_addr == issue_addr));
    assign w_issue_acc  = issue_valid && issue_ready && !w_issue_zero;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [NB-1:0] w_be;
        assign w_be = (w_wr_en && (wr_addr == AW'(g))) ? wr_be : '0;
        reg_entry #(.WIDTH(WIDTH)) u_entry (
            .clock  (clock),
            .reset  (reset),
            .i_be   (w_be),
            .i_data (wr_data),
            .o_q    (w_entry_q[g])
        );
    end

    assign w_rd_addr[0] = rd_addr_a;
    assign w_rd_addr[1] = rd_addr_b;

    // Read ports: array contents, optional write-through merge, forced zero for entry 0.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_data[p]  = w_entry_q[w_rd_addr[p]];
            w_rd_valid[p] = !r_pending[w_rd_addr[p]];
`ifdef RF_BYPASS_EN
            for (int b = 0; b < NB; b++) begin
                w_rd_data[p][8*b +: 8] = (w_wr_en && (wr_addr == w_rd_addr[p]) && wr_be[b]) ?
                                         wr_data[8*b +: 8] : w_entry_q[w_rd_addr[p]][8*b +: 8];
            end
            w_rd_valid[p] = !r_pending[w_rd_addr[p]] || (we && (wr_addr == w_rd_addr[p]));
`endif
            if (ZR && (w_rd_addr[p] == '0)) begin
                w_rd_data[p]  = '0;
                w_rd_valid[p] = 1'b1;
            end else begin
                w_rd_valid[p] = w_rd_valid[p];
            end
        end
    end

    // Next pending vector: an accepted issue wins over a same-address writeback clear.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_pending_next[i] = (w_issue_acc && (issue_addr == AW'(i))) ||
                                (r_pending[i] && !(w_wr_en && (wr_addr == AW'(i))));
        end
    end

    // Scoreboard state and running count of pending entries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending    <= '0;
            r_busy_count <= '0;
        end else begin
            r_pending <= w_pending_next;
            case ({w_issue_acc, w_wr_clear})
                2'b10:   r_busy_count <= r_busy_count + (AW+1)'(1);
                2'b01:   r_busy_count <= r_busy_count - (AW+1)'(1);
                default: r_busy_count <= r_busy_count;
            endcase
        end
    end

    assign rd_data_a  = w_rd_data[0];
    assign rd_valid_a = w_rd_valid[0];
    assign rd_data_b  = w_rd_data[1];
    assign rd_valid_b = w_rd_valid[1];
    assign busy_count = r_busy_count;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb (default 64x32, ZERO_REG=1).
module tb_reg_file_sb;
    import reg_file_pkg::*;

    logic        clock;
    logic        reset;
    addr_t       rd_addr_a, rd_addr_b, wr_addr, issue_addr;
    logic [63:0] rd_data_a, rd_data_b, wr_data;
    logic        rd_valid_a, rd_valid_b, we, issue_valid, issue_ready;
    be_t         wr_be;
    logic [5:0]  busy_count;

    int checks = 0;
    int errors = 0;
    string       tag_q [$];
    logic [63:0] exp_q [$];

    reg_file_sb dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr_a   (rd_addr_a),
        .rd_data_a   (rd_data_a),
        .rd_valid_a  (rd_valid_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_b   (rd_data_b),
        .rd_valid_b  (rd_valid_b),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .busy_count  (busy_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic push(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        string       tag;
        logic [63:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed %h", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; rd_addr_a = '0; rd_addr_b = '0; we = 1'b0; wr_addr = '0;
        wr_data = 64'h0; wr_be = '0; issue_valid = 1'b0; issue_addr = '0;
        repeat (2) step();

        // reset release
        reset = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd31;
        push("rst_data_a", 64'h0); push("rst_valid_a", 64'h1);
        push("rst_data_b", 64'h0); push("rst_valid_b", 64'h1);
        push("rst_busy", 64'h0);   push("rst_ready", 64'h1);
        #2;
        pop_check(rd_data_a); pop_check({63'h0, rd_valid_a});
        pop_check(rd_data_b); pop_check({63'h0, rd_valid_b});
        pop_check({58'h0, busy_count}); pop_check({63'h0, issue_ready});

        // issue 7
        issue_valid = 1'b1; issue_addr = 5'd7;
        push("issue7_ready", 64'h1); #2; pop_check({63'h0, issue_ready});
        step();
        issue_valid = 1'b0; rd_addr_a = 5'd7;
        push("pend7_valid", 64'h0); push("pend7_busy", 64'h1); #2;
        pop_check({63'h0, rd_valid_a}); pop_check({58'h0, busy_count});
        issue_valid = 1'b1;
        push("waw7_ready", 64'h0); #2; pop_check({63'h0, issue_ready});
        issue_valid = 1'b0;

        // writeback 7 while reading 7
        step();
        we = 1'b1; wr_addr = 5'd7; wr_data = 64'h1122334455667788; wr_be = 8'hFF;
`ifdef RF_BYPASS_EN
        push("wb7_data", 64'h1122334455667788); push("wb7_valid", 64'h1);
`else
        push("wb7_data", 64'h0); push("wb7_valid", 64'h0);
`endif
        #2; pop_check(rd_data_a); pop_check({63'h0, rd_valid_a});
        step();
        we = 1'b0;
        push("after7_data", 64'h1122334455667788); push("after7_valid", 64'h1);
        push("after7_busy", 64'h0);
        #2; pop_check(rd_data_a); pop_check({63'h0, rd_valid_a}); pop_check({58'h0, busy_count});

        // partial byte write on entry 3
        we = 1'b1; wr_addr = 5'd3; wr_data = 64'hFFFF_FFFF_FFFF_FFFF; wr_be = 8'hFF;
        step();
        wr_data = 64'h0; wr_be = 8'h0F;
        step();
        we = 1'b0; rd_addr_b = 5'd3;
        push("be3_data", 64'hFFFF_FFFF_0000_0000); push("be3_valid", 64'h1);
        #2; pop_check(rd_data_b); pop_check({63'h0, rd_valid_b});

        // issue 9, then issue + writeback 9 in one cycle
        issue_valid = 1'b1; issue_addr = 5'd9;
        step();
        issue_valid = 1'b1; we = 1'b1; wr_addr = 5'd9; wr_data = 64'hDEAD_BEEF_0000_1234; wr_be = 8'hFF;
        push("same9_busy_before", 64'h1); push("same9_ready", 64'h1);
        #2; pop_check({58'h0, busy_count}); pop_check({63'h0, issue_ready});
        step();
        issue_valid = 1'b0; we = 1'b0; rd_addr_a = 5'd9; rd_addr_b = 5'd9;
        push("same9_valid_a", 64'h0); push("same9_data_a", 64'hDEAD_BEEF_0000_1234);
        push("same9_busy", 64'h1);
        push("same9_data_b", 64'hDEAD_BEEF_0000_1234); push("same9_valid_b", 64'h0);
        #2; pop_check({63'h0, rd_valid_a}); pop_check(rd_data_a); pop_check({58'h0, busy_count});
        pop_check(rd_data_b); pop_check({63'h0, rd_valid_b});

        // issue 4 and 6, then asynchronous reset between edges
        issue_valid = 1'b1; issue_addr = 5'd4;
        step();
        issue_addr = 5'd6;
        step();
        issue_valid = 1'b0;
        push("pre_rst_busy", 64'h3); #1; pop_check({58'h0, busy_count});
        #1; reset = 1'b0; #1;
        push("mid_rst_busy", 64'h0); push("mid_rst_data_a", 64'h0); push("mid_rst_valid_a", 64'h1);
        push("mid_rst_ready", 64'h1);
        pop_check({58'h0, busy_count}); pop_check(rd_data_a); pop_check({63'h0, rd_valid_a});
        pop_check({63'h0, issue_ready});
        step();
        reset = 1'b1;

        // zero register ignores writes and issues
        we = 1'b1; wr_addr = 5'd0; wr_data = 64'hAB; wr_be = 8'hFF; rd_addr_a = 5'd0;
        issue_valid = 1'b1; issue_addr = 5'd0;
        push("zero_data_now", 64'h0); push("zero_valid_now", 64'h1); push("zero_ready", 64'h1);
        #2; pop_check(rd_data_a); pop_check({63'h0, rd_valid_a}); pop_check({63'h0, issue_ready});
        step();
        we = 1'b0; issue_valid = 1'b0;
        push("zero_data_after", 64'h0); push("zero_busy", 64'h0);
        #2; pop_check(rd_data_a); pop_check({58'h0, busy_count});

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
